// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the 2D-mesh wormhole router.
//   - port index constants (N, E, S, W, first local port)
//   - header field positions (field index times POS_WIDTH) and the tail bit
//   - route(): dimension-order output selection for a head flit
//   - out_state_t: per-output lock state
package noc_pkg;

   localparam int PORT_N     = 0;
   localparam int PORT_E     = 1;
   localparam int PORT_S     = 2;
   localparam int PORT_W     = 3;
   localparam int PORT_L0    = 4;
   localparam int PORT_IDX_W = 3;

   // Header fields are POS_WIDTH-wide slots; the local id occupies the third slot.
   localparam int DEST_X_FIELD   = 0;
   localparam int DEST_Y_FIELD   = 1;
   localparam int LOCAL_ID_FIELD = 2;
   localparam int LOCAL_ID_W     = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } out_state_t;

   function automatic int tail_bit(input int data_width);
      return data_width - 1;
   endfunction

   // Dimension-order routing; an out-of-range local id falls back to local 0.
   function automatic logic [PORT_IDX_W-1:0] route(
      input logic [31:0]           dest_x,
      input logic [31:0]           dest_y,
      input logic [31:0]           pos_x,
      input logic [31:0]           pos_y,
      input logic [LOCAL_ID_W-1:0] local_id,
      input logic                  route_yx,
      input logic [PORT_IDX_W-1:0] num_local
   );
      logic [PORT_IDX_W-1:0] local_port;
      logic [PORT_IDX_W-1:0] port;
      if ({1'b0, local_id} < num_local) begin
         local_port = PORT_IDX_W'(PORT_L0) + {1'b0, local_id};
      end else begin
         local_port = PORT_IDX_W'(PORT_L0);
      end
      if (route_yx) begin
         if (dest_y < pos_y)      port = PORT_IDX_W'(PORT_N);
         else if (dest_y > pos_y) port = PORT_IDX_W'(PORT_S);
         else if (dest_x > pos_x) port = PORT_IDX_W'(PORT_E);
         else if (dest_x < pos_x) port = PORT_IDX_W'(PORT_W);
         else                     port = local_port;
      end else begin
         if (dest_x > pos_x)      port = PORT_IDX_W'(PORT_E);
         else if (dest_x < pos_x) port = PORT_IDX_W'(PORT_W);
         else if (dest_y < pos_y) port = PORT_IDX_W'(PORT_N);
         else if (dest_y > pos_y) port = PORT_IDX_W'(PORT_S);
         else                     port = local_port;
      end
      return port;
   endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// noc_in_fifo: synchronous input FIFO for one router port.
// Ports: clk, rst (async, active low), push/wr_data (write side),
//        pop/rd_data (head peek and read), count, full, empty.
// The caller never pushes when full nor pops when empty.
module noc_in_fifo
   import noc_pkg::*;
#(
   parameter  int DATA_WIDTH = 216,
   parameter  int DEPTH      = 16,
   localparam int AW         = $clog2(DEPTH),
   localparam int CNT_W      = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]         wr_ptr_r;
   logic [AW-1:0]         rd_ptr_r;
   logic [CNT_W-1:0]      count_r;

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;
   assign full    = (count_r == CNT_W'(DEPTH));
   assign empty   = (count_r == {CNT_W{1'b0}});

   // Storage array; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({push, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/noc_router_mesh.sv
// noc_router_mesh: parametrised wormhole router for one mesh tile.
// Ports: clk, rst (async, active low);
//        in_data/in_valid/in_busy  - P input links (busy = FIFO full);
//        out_data/out_valid/out_busy - P output links (busy = downstream stall).
// P = 4 + NUM_LOCAL; port 0..3 = N, E, S, W, then local 0..NUM_LOCAL-1.
// Each output arbitrates round-robin among head flits and then stays locked
// to the winning input until that packet's tail flit has been taken.
module noc_router_mesh
   import noc_pkg::*;
#(
   parameter  int DATA_WIDTH = 216,
   parameter  int FIFO_DEPTH = 16,
   parameter  int POS_WIDTH  = 4,
   parameter  int POS_X      = 1,
   parameter  int POS_Y      = 1,
   parameter  int NUM_LOCAL  = 1,
   parameter  int ROUTE_YX   = 0,
   localparam int P          = 4 + NUM_LOCAL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [P*DATA_WIDTH-1:0] in_data,
   input  logic [P-1:0]            in_valid,
   output logic [P-1:0]            in_busy,
   output logic [P*DATA_WIDTH-1:0] out_data,
   output logic [P-1:0]            out_valid,
   input  logic [P-1:0]            out_busy
);

   localparam int TAIL_BIT     = tail_bit(DATA_WIDTH);
   localparam int DEST_X_LSB   = DEST_X_FIELD * POS_WIDTH;
   localparam int DEST_Y_LSB   = DEST_Y_FIELD * POS_WIDTH;
   localparam int LOCAL_ID_LSB = LOCAL_ID_FIELD * POS_WIDTH;
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [PORT_IDX_W-1:0] LAST_PORT = PORT_IDX_W'(P - 1);

   logic [DATA_WIDTH-1:0] head_data_s [P];
   logic [CNT_W-1:0]      fifo_count_s [P];
   logic [P-1:0]          fifo_full_s;
   logic [P-1:0]          fifo_empty_s;
   logic [P-1:0]          push_s;
   logic [P-1:0]          pop_s;

   // Per-input packet tracking: head_flag_r=1 means the FIFO head starts a packet.
   logic [P-1:0]          head_flag_r;
   logic [PORT_IDX_W-1:0] route_r [P];
   logic [PORT_IDX_W-1:0] req_port_s [P];

   // Per-output arbitration, lock and output register.
   out_state_t            state_r [P];
   logic [PORT_IDX_W-1:0] owner_r [P];
   logic [PORT_IDX_W-1:0] rr_ptr_r [P];
   logic [PORT_IDX_W-1:0] grant_idx_s [P];
   logic [PORT_IDX_W-1:0] sel_s [P];
   logic [P-1:0]          grant_vld_s;
   logic [P-1:0]          load_s;
   logic [P-1:0]          sel_tail_s;
   logic [DATA_WIDTH-1:0] out_data_r [P];
   logic [P-1:0]          out_valid_r;
   int                    cand_s;

   for (genvar i = 0; i < P; i++) begin : g_port
      noc_in_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push    (push_s[i]),
         .wr_data (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .pop     (pop_s[i]),
         .rd_data (head_data_s[i]),
         .count   (fifo_count_s[i]),
         .full    (fifo_full_s[i]),
         .empty   (fifo_empty_s[i])
      );
      assign push_s[i]  = in_valid[i] & ~fifo_full_s[i];
      assign in_busy[i] = (fifo_count_s[i] == CNT_W'(FIFO_DEPTH));
      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = out_data_r[i];
   end

   assign out_valid = out_valid_r;

   // Requested output per input: freshly routed for a head flit, held otherwise.
   always_comb begin
      for (int i = 0; i < P; i++) begin
         if (head_flag_r[i]) begin
            req_port_s[i] = route(32'(head_data_s[i][DEST_X_LSB +: POS_WIDTH]),
                                  32'(head_data_s[i][DEST_Y_LSB +: POS_WIDTH]),
                                  32'(POS_X), 32'(POS_Y),
                                  head_data_s[i][LOCAL_ID_LSB +: LOCAL_ID_W],
                                  (ROUTE_YX != 0), PORT_IDX_W'(NUM_LOCAL));
         end else begin
            req_port_s[i] = route_r[i];
         end
      end
   end

   // Round-robin search starting at each output's pointer.
   always_comb begin
      cand_s = 0;
      for (int o = 0; o < P; o++) begin
         grant_vld_s[o] = 1'b0;
         grant_idx_s[o] = {PORT_IDX_W{1'b0}};
         for (int k = 0; k < P; k++) begin
            cand_s = (int'(rr_ptr_r[o]) + k) % P;
            if (!grant_vld_s[o] && !fifo_empty_s[cand_s] &&
                (req_port_s[cand_s] == PORT_IDX_W'(o))) begin
               grant_vld_s[o] = 1'b1;
               grant_idx_s[o] = PORT_IDX_W'(cand_s);
            end else begin
               grant_vld_s[o] = grant_vld_s[o];
            end
         end
      end
   end

   // Crossbar select and load: the register loads when it is empty or being drained.
   always_comb begin
      for (int o = 0; o < P; o++) begin
         if (state_r[o] == ST_LOCKED) begin
            sel_s[o]  = owner_r[o];
            load_s[o] = (~out_valid_r[o] | ~out_busy[o]) & ~fifo_empty_s[owner_r[o]];
         end else begin
            sel_s[o]  = grant_idx_s[o];
            load_s[o] = (~out_valid_r[o] | ~out_busy[o]) & grant_vld_s[o];
         end
         sel_tail_s[o] = head_data_s[sel_s[o]][TAIL_BIT];
      end
      for (int i = 0; i < P; i++) begin
         pop_s[i] = 1'b0;
         for (int o = 0; o < P; o++) begin
            pop_s[i] = pop_s[i] | (load_s[o] & (sel_s[o] == PORT_IDX_W'(i)));
         end
      end
   end

   // Per-input head tracking; the route is captured when a non-tail head departs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_flag_r <= {P{1'b1}};
         for (int i = 0; i < P; i++) route_r[i] <= {PORT_IDX_W{1'b0}};
      end else begin
         for (int i = 0; i < P; i++) begin
            if (pop_s[i]) begin
               if (head_data_s[i][TAIL_BIT]) begin
                  head_flag_r[i] <= 1'b1;
               end else begin
                  head_flag_r[i] <= 1'b0;
                  route_r[i]     <= req_port_s[i];
               end
            end
         end
      end
   end

   // Per-output lock FSM, round-robin pointer and output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= {P{1'b0}};
         for (int o = 0; o < P; o++) begin
            state_r[o]    <= ST_IDLE;
            owner_r[o]    <= {PORT_IDX_W{1'b0}};
            rr_ptr_r[o]   <= {PORT_IDX_W{1'b0}};
            out_data_r[o] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         for (int o = 0; o < P; o++) begin
            if (load_s[o]) begin
               out_data_r[o]  <= head_data_s[sel_s[o]];
               out_valid_r[o] <= 1'b1;
            end else if (!out_busy[o]) begin
               out_valid_r[o] <= 1'b0;
            end
            case (state_r[o])
               ST_IDLE: begin
                  if (load_s[o]) begin
                     owner_r[o]  <= grant_idx_s[o];
                     rr_ptr_r[o] <= (grant_idx_s[o] == LAST_PORT) ?
                                    {PORT_IDX_W{1'b0}} : grant_idx_s[o] + 1'b1;
                     // A single-flit packet never holds the lock.
                     state_r[o]  <= sel_tail_s[o] ? ST_IDLE : ST_LOCKED;
                  end
               end
               ST_LOCKED: begin
                  if (load_s[o] && sel_tail_s[o]) state_r[o] <= ST_IDLE;
               end
               default: state_r[o] <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_noc_router_mesh.sv
// Directed bench: two routers at (1,1) with two local ports, one XY and one YX,
// share all inputs so the same stimulus shows both routing orders.
module tb_noc_router_mesh;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int P     = 6;
   localparam int N = 0, E = 1, S = 2, W = 3, L0 = 4, L1 = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [P*DW-1:0] in_data;
   logic [P-1:0]    in_valid;
   logic [P-1:0]    out_busy;
   logic [P-1:0]    in_busy_xy, in_busy_yx;
   logic [P*DW-1:0] out_data_xy, out_data_yx;
   logic [P-1:0]    out_valid_xy, out_valid_yx;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   noc_router_mesh #(
      .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .POS_WIDTH (4),
      .POS_X (1), .POS_Y (1), .NUM_LOCAL (2), .ROUTE_YX (0)
   ) dut_xy (
      .clk (clk), .rst (rst),
      .in_data (in_data), .in_valid (in_valid), .in_busy (in_busy_xy),
      .out_data (out_data_xy), .out_valid (out_valid_xy), .out_busy (out_busy)
   );

   noc_router_mesh #(
      .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .POS_WIDTH (4),
      .POS_X (1), .POS_Y (1), .NUM_LOCAL (2), .ROUTE_YX (1)
   ) dut_yx (
      .clk (clk), .rst (rst),
      .in_data (in_data), .in_valid (in_valid), .in_busy (in_busy_yx),
      .out_data (out_data_yx), .out_valid (out_valid_yx), .out_busy (out_busy)
   );

   // Flit layout for 16 bits: {tail, 5'b0, id[1:0], dest_y[3:0], dest_x[3:0]}.
   function automatic logic [DW-1:0] mk(input logic tail, input logic [1:0] id,
                                        input logic [3:0] dy, input logic [3:0] dx);
      return {tail, 5'b00000, id, dy, dx};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int port, input logic [DW-1:0] flit);
      in_data[port*DW +: DW] = flit;
      in_valid[port]         = 1'b1;
   endtask

   task automatic do_reset();
      in_valid = '0;
      out_busy = '0;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      in_valid = '0;
      in_data  = '0;
      out_busy = '0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      repeat (3) tick();
      n_cmp++; if (out_valid_xy !== 6'b000000) begin n_bad++; $display("FAIL reset_out_valid: got %b want 000000", out_valid_xy); end
      n_cmp++; if (out_data_xy !== 96'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data_xy); end
      n_cmp++; if (in_busy_xy !== 6'b000000) begin n_bad++; $display("FAIL reset_in_busy: got %b want 000000", in_busy_xy); end
      n_cmp++; if (out_valid_yx !== 6'b000000) begin n_bad++; $display("FAIL reset_out_valid_yx: got %b want 000000", out_valid_yx); end
      rst = 1'b1;
      tick();
      n_cmp++; if (out_valid_xy !== 6'b000000) begin n_bad++; $display("FAIL reset_release_valid: got %b want 000000", out_valid_xy); end
   endtask

   task automatic test_basic();
      logic [DW-1:0] f;
      do_reset();
      f = mk(1'b1, 2'd0, 4'd1, 4'd3);
      drive(W, f);
      tick();
      in_valid = '0;
      n_cmp++; if (out_valid_xy !== 6'b000000) begin n_bad++; $display("FAIL basic_early: got %b want 000000", out_valid_xy); end
      tick();
      n_cmp++; if (out_valid_xy !== 6'b000010) begin n_bad++; $display("FAIL basic_valid: got %b want 000010", out_valid_xy); end
      n_cmp++; if (out_data_xy[E*DW +: DW] !== f) begin n_bad++; $display("FAIL basic_data: got %h want %h", out_data_xy[E*DW +: DW], f); end
      n_cmp++; if (out_valid_yx !== 6'b000010) begin n_bad++; $display("FAIL basic_valid_yx: got %b want 000010", out_valid_yx); end
      tick();
      n_cmp++; if (out_valid_xy !== 6'b000000) begin n_bad++; $display("FAIL basic_drain: got %b want 000000", out_valid_xy); end
   endtask

   task automatic test_wormhole();
      logic [DW-1:0] nf [3];
      logic [DW-1:0] sf [3];
      logic [DW-1:0] exp_seq [6];
      logic [DW-1:0] obs;
      logic [DW-1:0] got [$];
      do_reset();
      nf = '{mk(1'b0, 2'd0, 4'd1, 4'd3), 16'h0101, 16'h8102};
      sf = '{mk(1'b0, 2'd0, 4'd2, 4'd3), 16'h0201, 16'h8202};
      for (int k = 0; k < 3; k++) begin
         exp_seq[k]     = nf[k];
         exp_seq[k + 3] = sf[k];
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc < 3) begin
            drive(N, nf[cyc]);
            drive(S, sf[cyc]);
         end else begin
            in_valid = '0;
         end
         if (out_valid_xy[E]) got.push_back(out_data_xy[E*DW +: DW]);
         tick();
      end
      n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL worm_count: got %0d want 6", got.size()); end
      for (int k = 0; k < 6; k++) begin
         obs = (k < got.size()) ? got[k] : 16'hxxxx;
         n_cmp++; if (obs !== exp_seq[k]) begin n_bad++; $display("FAIL worm_flit%0d: got %h want %h", k, obs, exp_seq[k]); end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] bp [8];
      logic [DW-1:0] obs;
      logic [DW-1:0] got [$];
      int sent;
      int busy_at;
      do_reset();
      bp[0] = mk(1'b0, 2'd0, 4'd1, 4'd3);
      for (int k = 1; k < 7; k++) bp[k] = 16'h3000 | 16'(k);
      bp[7] = 16'hB007;
      sent    = 0;
      busy_at = -1;
      out_busy[E] = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc == 12) out_busy[E] = 1'b0;
         if (sent < 8) drive(W, bp[sent]);
         else in_valid[W] = 1'b0;
         if (busy_at < 0 && in_busy_xy[W]) busy_at = sent;
         if (cyc == 10) begin
            n_cmp++; if (out_valid_xy[E] !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 1", out_valid_xy[E]); end
            n_cmp++; if (out_data_xy[E*DW +: DW] !== bp[0]) begin n_bad++; $display("FAIL bp_hold_data: got %h want %h", out_data_xy[E*DW +: DW], bp[0]); end
         end
         if (cyc == 12) begin
            n_cmp++; if (in_busy_xy[W] !== 1'b1) begin n_bad++; $display("FAIL bp_busy_held: got %b want 1", in_busy_xy[W]); end
         end
         if (cyc == 13) begin
            n_cmp++; if (in_busy_xy[W] !== 1'b0) begin n_bad++; $display("FAIL bp_busy_release: got %b want 0", in_busy_xy[W]); end
         end
         if (in_valid[W] && !in_busy_xy[W]) sent++;
         if (out_valid_xy[E] && !out_busy[E]) got.push_back(out_data_xy[E*DW +: DW]);
         tick();
      end
      in_valid = '0;
      // The FIFO fills after DEPTH flits, plus the head already parked in the output register.
      n_cmp++; if (busy_at != DEPTH + 1) begin n_bad++; $display("FAIL bp_busy_point: got %0d want %0d", busy_at, DEPTH + 1); end
      n_cmp++; if (got.size() != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", got.size()); end
      for (int k = 0; k < 8; k++) begin
         obs = (k < got.size()) ? got[k] : 16'hxxxx;
         n_cmp++; if (obs !== bp[k]) begin n_bad++; $display("FAIL bp_flit%0d: got %h want %h", k, obs, bp[k]); end
      end
   endtask

   task automatic test_yx();
      logic [DW-1:0] f;
      do_reset();
      f = mk(1'b1, 2'd0, 4'd0, 4'd3);
      drive(L0, f);
      tick();
      in_valid = '0;
      tick();
      n_cmp++; if (out_valid_xy !== 6'b000010) begin n_bad++; $display("FAIL xy_port: got %b want 000010", out_valid_xy); end
      n_cmp++; if (out_data_xy[E*DW +: DW] !== f) begin n_bad++; $display("FAIL xy_data: got %h want %h", out_data_xy[E*DW +: DW], f); end
      n_cmp++; if (out_valid_yx !== 6'b000001) begin n_bad++; $display("FAIL yx_port: got %b want 000001", out_valid_yx); end
      n_cmp++; if (out_data_yx[N*DW +: DW] !== f) begin n_bad++; $display("FAIL yx_data: got %h want %h", out_data_yx[N*DW +: DW], f); end
      tick();
   endtask

   task automatic test_local();
      logic [DW-1:0] f;
      do_reset();
      f = mk(1'b1, 2'd1, 4'd1, 4'd1);
      drive(E, f);
      tick();
      in_valid = '0;
      tick();
      n_cmp++; if (out_valid_xy !== 6'b100000) begin n_bad++; $display("FAIL local1_port: got %b want 100000", out_valid_xy); end
      n_cmp++; if (out_data_xy[L1*DW +: DW] !== f) begin n_bad++; $display("FAIL local1_data: got %h want %h", out_data_xy[L1*DW +: DW], f); end
      tick();
      f = mk(1'b1, 2'd3, 4'd1, 4'd1);
      drive(E, f);
      tick();
      in_valid = '0;
      tick();
      n_cmp++; if (out_valid_xy !== 6'b010000) begin n_bad++; $display("FAIL local3_port: got %b want 010000", out_valid_xy); end
      n_cmp++; if (out_data_xy[L0*DW +: DW] !== f) begin n_bad++; $display("FAIL local3_data: got %h want %h", out_data_xy[L0*DW +: DW], f); end
      tick();
   endtask

   task automatic test_reset_mid_packet();
      logic [DW-1:0] f;
      do_reset();
      drive(W, mk(1'b0, 2'd0, 4'd1, 4'd3));
      tick();
      drive(W, 16'h4001);
      tick();
      in_valid = '0;
      rst = 1'b0;
      #1;
      n_cmp++; if (out_valid_xy !== 6'b000000) begin n_bad++; $display("FAIL midrst_valid: got %b want 000000", out_valid_xy); end
      tick();
      rst = 1'b1;
      tick();
      n_cmp++; if (out_valid_xy !== 6'b000000) begin n_bad++; $display("FAIL midrst_after: got %b want 000000", out_valid_xy); end
      // New single-flit packet on W heading S must be routed as a head.
      f = mk(1'b1, 2'd0, 4'd2, 4'd1);
      drive(W, f);
      tick();
      in_valid = '0;
      tick();
      n_cmp++; if (out_valid_xy !== 6'b000100) begin n_bad++; $display("FAIL midrst_route: got %b want 000100", out_valid_xy); end
      n_cmp++; if (out_data_xy[S*DW +: DW] !== f) begin n_bad++; $display("FAIL midrst_data: got %h want %h", out_data_xy[S*DW +: DW], f); end
      tick();
      // E must be free again: a packet from S reaches it.
      f = mk(1'b1, 2'd0, 4'd1, 4'd3);
      drive(S, f);
      tick();
      in_valid = '0;
      tick();
      n_cmp++; if (out_valid_xy !== 6'b000010) begin n_bad++; $display("FAIL midrst_unlock: got %b want 000010", out_valid_xy); end
      n_cmp++; if (out_data_xy[E*DW +: DW] !== f) begin n_bad++; $display("FAIL midrst_unlock_data: got %h want %h", out_data_xy[E*DW +: DW], f); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wormhole();
      test_backpressure();
      test_yx();
      test_local();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
